// File: rtl/murmur_dispatch.sv
// Round-robin tuple dispatcher for the murmur hasher array: serial-tags each accepted tuple,
// feeds one-entry lane registers, and flags end-of-stream once every lane has drained.
module murmur_dispatch #(
   parameter int unsigned NUM_HASHER = 8,
   parameter int unsigned SERIAL_W   = 64
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic [63:0]                            in_data,
   input  logic                                   in_valid,
   input  logic                                   in_last,
   output logic                                   in_ready,
   output logic [NUM_HASHER-1:0][63:0]            hash_in_data,
   output logic [NUM_HASHER-1:0]                  hash_in_valid,
   input  logic [NUM_HASHER-1:0]                  hash_in_ready,
   output logic [NUM_HASHER-1:0][SERIAL_W-1:0]    hash_in_serialnum,
   output logic [NUM_HASHER-1:0]                  hash_in_last_processed,
   output logic                                   done,
   output logic [SERIAL_W-1:0]                    tuple_count
);

   localparam int unsigned PtrW = (NUM_HASHER > 1) ? $clog2(NUM_HASHER) : 1;

   typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

   state_e                state;
   logic [PtrW-1:0]       ptr;
   logic [PtrW-1:0]       grant;
   logic [PtrW-1:0]       ptr_next;
   logic                  grant_found;
   logic [NUM_HASHER-1:0] free;
   logic                  accept;

   // A lane draining this cycle can be refilled in the same cycle.
   assign free = ~hash_in_valid | hash_in_ready;

   always_comb begin
      int unsigned idx;
      idx         = 0;
      grant       = ptr;
      grant_found = 1'b0;
      for (int unsigned k = 0; k < NUM_HASHER; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= NUM_HASHER) idx = idx - NUM_HASHER;
         if (!grant_found && free[idx[PtrW-1:0]]) begin
            grant       = idx[PtrW-1:0];
            grant_found = 1'b1;
         end
      end
   end

   assign ptr_next = (grant == PtrW'(NUM_HASHER - 1)) ? '0 : grant + PtrW'(1);
   assign in_ready = (state == StRun) && grant_found && !reset;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state                  <= StRun;
         ptr                    <= '0;
         tuple_count            <= '0;
         hash_in_valid          <= '0;
         hash_in_data           <= '0;
         hash_in_serialnum      <= '0;
         hash_in_last_processed <= '0;
         done                   <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_HASHER; i++) begin
            if (accept && (grant == PtrW'(i))) begin
               hash_in_valid[i]     <= 1'b1;
               hash_in_data[i]      <= in_data;
               hash_in_serialnum[i] <= tuple_count;
            end else if (hash_in_valid[i] && hash_in_ready[i]) begin
               hash_in_valid[i] <= 1'b0;
            end
         end

         case (state)
            StRun: begin
               if (accept) begin
                  tuple_count <= tuple_count + SERIAL_W'(1);
                  ptr         <= ptr_next;
                  if (in_last) state <= StDrain;
               end
            end
            StDrain: begin
               if (hash_in_valid == '0) begin
                  state                  <= StDone;
                  hash_in_last_processed <= '1;
                  done                   <= 1'b1;
               end
            end
            StDone: begin
               if (start) begin
                  state                  <= StRun;
                  hash_in_last_processed <= '0;
                  done                   <= 1'b0;
                  tuple_count            <= '0;
                  ptr                    <= '0;
               end
            end
            default: state <= StRun;
         endcase
      end
   end

endmodule

// File: tb/tb_murmur_dispatch.sv
// Directed bench for murmur_dispatch: a 4-lane instance for the main scenarios and a
// 3-lane, 4-bit-serial instance for pointer and serial wrap.
module tb_murmur_dispatch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [63:0]       in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_last = 1'b0;
   logic              in_ready;
   logic [3:0][63:0]  h_data;
   logic [3:0]        h_valid;
   logic [3:0]        h_ready = '0;
   logic [3:0][15:0]  h_serial;
   logic [3:0]        h_last;
   logic              done;
   logic [15:0]       tuple_count;

   logic              w_start = 1'b0;
   logic [63:0]       w_in_data = '0;
   logic              w_in_valid = 1'b0;
   logic              w_in_last = 1'b0;
   logic              w_in_ready;
   logic [2:0][63:0]  w_h_data;
   logic [2:0]        w_h_valid;
   logic [2:0]        w_h_ready = '0;
   logic [2:0][3:0]   w_h_serial;
   logic [2:0]        w_h_last;
   logic              w_done;
   logic [3:0]        w_tuple_count;

   murmur_dispatch #(.NUM_HASHER(4), .SERIAL_W(16)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .start                  (start),
      .in_data                (in_data),
      .in_valid               (in_valid),
      .in_last                (in_last),
      .in_ready               (in_ready),
      .hash_in_data           (h_data),
      .hash_in_valid          (h_valid),
      .hash_in_ready          (h_ready),
      .hash_in_serialnum      (h_serial),
      .hash_in_last_processed (h_last),
      .done                   (done),
      .tuple_count            (tuple_count)
   );

   murmur_dispatch #(.NUM_HASHER(3), .SERIAL_W(4)) dut3 (
      .clk                    (clk),
      .reset                  (reset),
      .start                  (w_start),
      .in_data                (w_in_data),
      .in_valid               (w_in_valid),
      .in_last                (w_in_last),
      .in_ready               (w_in_ready),
      .hash_in_data           (w_h_data),
      .hash_in_valid          (w_h_valid),
      .hash_in_ready          (w_h_ready),
      .hash_in_serialnum      (w_h_serial),
      .hash_in_last_processed (w_h_last),
      .done                   (w_done),
      .tuple_count            (w_tuple_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if (h_valid !== 4'h0) begin failures++; $display("FAIL reset_valid got=%h exp=0", h_valid); end
      checks++; if (h_last !== 4'h0) begin failures++; $display("FAIL reset_last got=%h exp=0", h_last); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (tuple_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", tuple_count); end
      checks++; if (h_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", h_data); end
      reset = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_all_ready();
      int lanes[6] = '{0, 1, 2, 3, 0, 1};
      int lane;
      h_ready = 4'hF;
      for (int i = 0; i < 6; i++) begin
         in_data = 64'hA0 + 64'(i); in_valid = 1'b1; in_last = (i == 5);
         #1;
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ar_in_ready[%0d] got=%b exp=1", i, in_ready); end
         tick();
         lane = lanes[i];
         checks++; if (h_valid !== 4'(1 << lane)) begin failures++; $display("FAIL ar_valid[%0d] got=%h exp=%h", i, h_valid, 4'(1 << lane)); end
         checks++; if (h_data[lane] !== 64'hA0 + 64'(i)) begin failures++; $display("FAIL ar_data[%0d] got=%h exp=%h", i, h_data[lane], 64'hA0 + 64'(i)); end
         checks++; if (h_serial[lane] !== 16'(i)) begin failures++; $display("FAIL ar_serial[%0d] got=%0d exp=%0d", i, h_serial[lane], i); end
      end
      in_valid = 1'b0; in_last = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ar_drain_in_ready got=%b exp=0", in_ready); end
      tick();
      checks++; if (h_valid !== 4'h0) begin failures++; $display("FAIL ar_drained got=%h exp=0", h_valid); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL ar_done_early got=%b exp=0", done); end
      tick();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL ar_done got=%b exp=1", done); end
      checks++; if (h_last !== 4'hF) begin failures++; $display("FAIL ar_last got=%h exp=f", h_last); end
      checks++; if (tuple_count !== 16'd6) begin failures++; $display("FAIL ar_count got=%0d exp=6", tuple_count); end
   endtask

   task automatic test_restart();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL rs_done got=%b exp=0", done); end
      checks++; if (h_last !== 4'h0) begin failures++; $display("FAIL rs_last got=%h exp=0", h_last); end
      checks++; if (tuple_count !== 16'd0) begin failures++; $display("FAIL rs_count got=%0d exp=0", tuple_count); end
      for (int i = 0; i < 2; i++) begin
         in_data = 64'hB0 + 64'(i); in_valid = 1'b1; in_last = (i == 1);
         tick();
         checks++; if (h_valid[i] !== 1'b1) begin failures++; $display("FAIL rs_valid[%0d] got=%h", i, h_valid); end
         checks++; if (h_serial[i] !== 16'(i)) begin failures++; $display("FAIL rs_serial[%0d] got=%0d exp=%0d", i, h_serial[i], i); end
         checks++; if (h_last !== 4'h0) begin failures++; $display("FAIL rs_last_run[%0d] got=%h exp=0", i, h_last); end
      end
      in_valid = 1'b0; in_last = 1'b0;
      tick();
      tick();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL rs_done_end got=%b exp=1", done); end
      checks++; if (h_last !== 4'hF) begin failures++; $display("FAIL rs_last_end got=%h exp=f", h_last); end
   endtask

   task automatic test_stall_lane1();
      int lanes[6] = '{0, 1, 2, 3, 0, 2};
      int lane;
      start = 1'b1;
      tick();
      start = 1'b0;
      h_ready = 4'b1101;
      for (int i = 0; i < 6; i++) begin
         in_data = 64'hC0 + 64'(i); in_valid = 1'b1; in_last = (i == 5);
         #1;
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL sl_in_ready[%0d] got=%b exp=1", i, in_ready); end
         tick();
         lane = lanes[i];
         checks++; if (h_valid[lane] !== 1'b1) begin failures++; $display("FAIL sl_grant[%0d] got=%h exp lane %0d", i, h_valid, lane); end
         checks++; if (h_data[lane] !== 64'hC0 + 64'(i)) begin failures++; $display("FAIL sl_data[%0d] got=%h exp=%h", i, h_data[lane], 64'hC0 + 64'(i)); end
         checks++; if (h_serial[lane] !== 16'(i)) begin failures++; $display("FAIL sl_serial[%0d] got=%0d exp=%0d", i, h_serial[lane], i); end
         if (i >= 2) begin
            checks++; if (h_data[1] !== 64'hC1 || h_serial[1] !== 16'd1) begin
               failures++; $display("FAIL sl_hold[%0d] got=%h/%0d exp=c1/1", i, h_data[1], h_serial[1]);
            end
         end
      end
      in_valid = 1'b0; in_last = 1'b0;
      tick(); tick(); tick();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL sl_stuck_done got=%b exp=0", done); end
      checks++; if (h_valid !== 4'b0010) begin failures++; $display("FAIL sl_stuck_valid got=%h exp=2", h_valid); end
      h_ready = 4'hF;
      tick();
      checks++; if (h_valid !== 4'h0) begin failures++; $display("FAIL sl_release_valid got=%h exp=0", h_valid); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL sl_release_done got=%b exp=0", done); end
      tick();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL sl_done got=%b exp=1", done); end
   endtask

   task automatic test_all_stall();
      start = 1'b1;
      tick();
      start = 1'b0;
      h_ready = 4'h0;
      for (int i = 0; i < 4; i++) begin
         in_data = 64'hD0 + 64'(i); in_valid = 1'b1; in_last = 1'b0;
         tick();
         checks++; if (h_valid[i] !== 1'b1 || h_serial[i] !== 16'(i)) begin
            failures++; $display("FAIL as_fill[%0d] got=%h/%0d exp lane valid/%0d", i, h_valid, h_serial[i], i);
         end
      end
      in_data = 64'hD4; in_valid = 1'b1; in_last = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL as_in_ready_full got=%b exp=0", in_ready); end
      tick();
      checks++; if (tuple_count !== 16'd4) begin failures++; $display("FAIL as_no_accept got=%0d exp=4", tuple_count); end
      checks++; if (h_data[0] !== 64'hD0) begin failures++; $display("FAIL as_hold0 got=%h exp=d0", h_data[0]); end
      h_ready = 4'b0100;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL as_in_ready_lane2 got=%b exp=1", in_ready); end
      tick();
      checks++; if (h_valid !== 4'hF) begin failures++; $display("FAIL as_refill_valid got=%h exp=f", h_valid); end
      checks++; if (h_data[2] !== 64'hD4 || h_serial[2] !== 16'd4) begin
         failures++; $display("FAIL as_refill got=%h/%0d exp=d4/4", h_data[2], h_serial[2]);
      end
      checks++; if (tuple_count !== 16'd5) begin failures++; $display("FAIL as_count got=%0d exp=5", tuple_count); end
      in_valid = 1'b0; in_last = 1'b0;
      h_ready = 4'b0001;
      tick();
      checks++; if (h_valid !== 4'b1110) begin failures++; $display("FAIL as_three_valid got=%h exp=e", h_valid); end
   endtask

   task automatic test_reset_in_drain();
      h_ready = 4'h0;
      reset = 1'b1;
      tick();
      checks++; if (h_valid !== 4'h0) begin failures++; $display("FAIL rd_valid got=%h exp=0", h_valid); end
      checks++; if (h_last !== 4'h0) begin failures++; $display("FAIL rd_last got=%h exp=0", h_last); end
      checks++; if (tuple_count !== 16'd0) begin failures++; $display("FAIL rd_count got=%0d exp=0", tuple_count); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL rd_done got=%b exp=0", done); end
      reset = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rd_run got=%b exp=1", in_ready); end
   endtask

   task automatic test_wrap();
      int lane;
      w_h_ready = 3'b111;
      for (int i = 0; i < 17; i++) begin
         w_in_data = 64'hE0 + 64'(i); w_in_valid = 1'b1; w_in_last = (i == 16);
         tick();
         lane = i % 3;
         checks++; if (w_h_valid !== 3'(1 << lane)) begin failures++; $display("FAIL wr_valid[%0d] got=%b exp=%b", i, w_h_valid, 3'(1 << lane)); end
         checks++; if (w_h_serial[lane] !== 4'(i % 16)) begin failures++; $display("FAIL wr_serial[%0d] got=%0d exp=%0d", i, w_h_serial[lane], i % 16); end
         checks++; if (w_h_data[lane] !== 64'hE0 + 64'(i)) begin failures++; $display("FAIL wr_data[%0d] got=%h", i, w_h_data[lane]); end
      end
      w_in_valid = 1'b0; w_in_last = 1'b0;
      tick();
      tick();
      checks++; if (w_done !== 1'b1) begin failures++; $display("FAIL wr_done got=%b exp=1", w_done); end
      checks++; if (w_h_last !== 3'b111) begin failures++; $display("FAIL wr_last got=%b exp=111", w_h_last); end
      checks++; if (w_tuple_count !== 4'd1) begin failures++; $display("FAIL wr_count got=%0d exp=1", w_tuple_count); end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_all_ready();
      test_restart();
      test_stall_lane1();
      test_all_stall();
      test_reset_in_drain();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
